rr_arb_mux: RTL and testbench

//   Parametrised N-channel, WIDTH-bit arbitrating multiplexer with valid/ready

---
 rtl/rr_arb_mux.sv | 89 ++++++++
 tb/tb_rr_arb_mux.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer: one requester per cycle is granted
// (round-robin or fixed priority) into a single registered output stage.
module rr_arb_mux #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int MODE  = 0,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  // Handshake: a word moves on channel i when in_valid[i] & in_ready[i];
  // the output word retires when out_valid & out_ready. in_ready never
  // depends on itself, and the stage accepts only when empty or retiring.

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [SELW-1:0]  grant;
  logic             found;
  logic             load;
  logic             any_valid;
  int               scan_idx;

  assign load      = !out_valid_q || out_ready;
  assign any_valid = |in_valid;

  // Scan upward from the pointer, wrapping, and take the first requester.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
      if (!found && in_valid[scan_idx]) begin
        grant = SELW'(scan_idx);
        found = 1'b1;
      end
    end
  end

  // Held low during reset so no producer sees an accept it cannot complete.
  always_comb begin
    in_ready = '0;
    if (reset_n && load && any_valid) in_ready[grant] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == 0 && load && any_valid) begin
      ptr_d = (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        if (any_valid) begin
          out_valid_q <= 1'b1;
          out_data_q  <= in_data[int'(grant)*WIDTH +: WIDTH];
          out_sel_q   <= grant;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: one round-robin and one fixed-priority
// instance, a vector table for streaming/skip/stall, and hand sequences.
module tb_rr_arb_mux;

  localparam int NCH   = 4;
  localparam int WIDTH = 32;
  localparam int SELW  = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic [NCH-1:0]       rr_valid, rr_ready, fp_valid, fp_ready;
  logic [NCH*WIDTH-1:0] rr_data, fp_data;
  logic                 rr_ov, fp_ov, rr_ordy, fp_ordy;
  logic [WIDTH-1:0]     rr_od, fp_od;
  logic [SELW-1:0]      rr_os, fp_os;

  rr_arb_mux #(.NCH(NCH), .WIDTH(WIDTH), .MODE(0)) u_rr (
    .clock(clock), .reset_n(reset_n),
    .in_valid(rr_valid), .in_data(rr_data), .in_ready(rr_ready),
    .out_valid(rr_ov), .out_data(rr_od), .out_sel(rr_os), .out_ready(rr_ordy)
  );

  rr_arb_mux #(.NCH(NCH), .WIDTH(WIDTH), .MODE(1)) u_fp (
    .clock(clock), .reset_n(reset_n),
    .in_valid(fp_valid), .in_data(fp_data), .in_ready(fp_ready),
    .out_valid(fp_ov), .out_data(fp_od), .out_sel(fp_os), .out_ready(fp_ordy)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_pop(input string name, input logic [WIDTH-1:0] act);
    logic [WIDTH-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %0h but no word expected", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, e, $time);
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_rr(input logic [NCH-1:0] v, input logic r);
    rr_valid = v;
    rr_ordy  = r;
    #1;
  endtask

  task automatic drive_fp(input logic [NCH-1:0] v, input logic r);
    fp_valid = v;
    fp_ordy  = r;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NCH-1:0]   valid;
    logic             ordy;
    logic [NCH-1:0]   exp_ready;
    logic             exp_ov;
    logic [SELW-1:0]  exp_sel;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // streaming from ptr=0 with wrap
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    // ptr=1, only ch0/ch2 request: 2, 0, 2
    vecs[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    vecs[6]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    vecs[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    // idle drains; empty stage loads even with out_ready low
    vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[9]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA1};
    vecs[11] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    vecs[12] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
  end

  // ---------------- test ----------------
  initial begin
    reset_n  = 1'b0;
    rr_valid = 4'b1111;
    fp_valid = 4'b1111;
    rr_ordy  = 1'b1;
    fp_ordy  = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      rr_data[i*WIDTH +: WIDTH] = 32'hA0 + i;
      fp_data[i*WIDTH +: WIDTH] = 32'hB0 + i;
    end

    // reset with every channel requesting
    repeat (2) step();
    chk("reset_out_valid", {63'd0, rr_ov}, 64'd0);
    chk("reset_out_data", {32'd0, rr_od}, 64'd0);
    chk("reset_out_sel", {62'd0, rr_os}, 64'd0);
    chk("reset_in_ready", {60'd0, rr_ready}, 64'd0);
    chk("reset_fp_in_ready", {60'd0, fp_ready}, 64'd0);
    reset_n  = 1'b1;
    fp_valid = 4'b0000;

    for (int i = 0; i < 14; i++) begin
      drive_rr(vecs[i].valid, vecs[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), {60'd0, rr_ready}, {60'd0, vecs[i].exp_ready});
      step();
      chk($sformatf("vec%0d_out_valid", i), {63'd0, rr_ov}, {63'd0, vecs[i].exp_ov});
      if (vecs[i].exp_ov) begin
        chk($sformatf("vec%0d_out_sel", i), {62'd0, rr_os}, {62'd0, vecs[i].exp_sel});
        chk($sformatf("vec%0d_out_data", i), {32'd0, rr_od}, {32'd0, vecs[i].exp_data});
      end
    end

    // backpressure: hold DEADBEEF from ch2 for 3 stalled cycles
    rr_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    drive_rr(4'b0100, 1'b1);
    chk("bp_load_ready", {60'd0, rr_ready}, 64'h4);
    exp_q.push_back(32'hDEADBEEF);
    step();
    chk("bp_load_sel", {62'd0, rr_os}, 64'd2);
    check_pop("bp_load_data", rr_od);
    for (int c = 0; c < 3; c++) begin
      drive_rr(4'b1111, 1'b0);
      chk($sformatf("bp_stall%0d_ready", c), {60'd0, rr_ready}, 64'd0);
      step();
      chk($sformatf("bp_stall%0d_valid", c), {63'd0, rr_ov}, 64'd1);
      chk($sformatf("bp_stall%0d_data", c), {32'd0, rr_od}, 64'hDEADBEEF);
      chk($sformatf("bp_stall%0d_sel", c), {62'd0, rr_os}, 64'd2);
    end
    drive_rr(4'b1111, 1'b1);
    chk("bp_release_ready", {60'd0, rr_ready}, 64'h8);
    exp_q.push_back(32'hA3);
    step();
    chk("bp_release_sel", {62'd0, rr_os}, 64'd3);
    check_pop("bp_release_data", rr_od);

    // async reset between edges while stalled with a held word
    drive_rr(4'b0001, 1'b1);
    step();
    chk("ar_loaded_valid", {63'd0, rr_ov}, 64'd1);
    drive_rr(4'b0000, 1'b0);
    chk("ar_stall_ready", {60'd0, rr_ready}, 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_out_valid", {63'd0, rr_ov}, 64'd0);
    chk("ar_out_data", {32'd0, rr_od}, 64'd0);
    chk("ar_out_sel", {62'd0, rr_os}, 64'd0);
    #1;
    reset_n = 1'b1;
    drive_rr(4'b1111, 1'b1);
    chk("ar_ptr0_ready", {60'd0, rr_ready}, 64'h1);
    exp_q.push_back(32'hA0);
    step();
    chk("ar_first_sel", {62'd0, rr_os}, 64'd0);
    check_pop("ar_first_data", rr_od);
    drive_rr(4'b0000, 1'b1);

    // fixed priority: ch1 always beats ch3 until ch1 drops
    for (int c = 0; c < 4; c++) begin
      drive_fp(4'b1010, 1'b1);
      chk($sformatf("fp%0d_ready", c), {60'd0, fp_ready}, 64'h2);
      exp_q.push_back(32'hB1);
      step();
      chk($sformatf("fp%0d_sel", c), {62'd0, fp_os}, 64'd1);
      check_pop($sformatf("fp%0d_data", c), fp_od);
    end
    drive_fp(4'b1000, 1'b1);
    chk("fp_drop_ready", {60'd0, fp_ready}, 64'h8);
    exp_q.push_back(32'hB3);
    step();
    chk("fp_drop_valid", {63'd0, fp_ov}, 64'd1);
    chk("fp_drop_sel", {62'd0, fp_os}, 64'd3);
    check_pop("fp_drop_data", fp_od);
    drive_fp(4'b0000, 1'b1);

    // ---------------- report ----------------
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
